// File: rtl/fifo_pop_skid_if.sv
// rtl/fifo_pop_skid_if.sv - FIFO read side plus registered output stream for fifo_pop_skid
interface fifo_pop_skid_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    // master: the drain stage (pops the FIFO, drives the output stream)
    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop,
        output m_valid,
        output m_data,
        input  m_ready
    );

    // slave: the FIFO plus the downstream consumer
    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_pop_skid.sv
// rtl/fifo_pop_skid.sv - FIFO drain stage with a 2-entry skid buffer on a registered stream
module fifo_pop_skid #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_pop_skid_if.master      bus,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] delivered_cnt
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    logic [WIDTH-1:0]     head;
    logic [WIDTH-1:0]     tail;
    logic [1:0]           occ;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 in_fire;
    logic                 out_fire;

    // Pop depends only on registered fill level, so m_ready never reaches fifo_pop.
    assign in_fire  = !rst && !bus.fifo_empty && (occ != OCC_TWO);
    assign out_fire = (occ != OCC_EMPTY) && bus.m_ready;

    assign bus.fifo_pop  = in_fire;
    assign bus.m_valid   = (occ != OCC_EMPTY);
    assign bus.m_data    = head;
    assign occupancy     = occ;
    assign delivered_cnt = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= OCC_EMPTY;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        head <= bus.fifo_data;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            tail <= bus.fifo_data;
                            occ  <= OCC_TWO;
                        end
                        2'b11: head <= bus.fifo_data;
                        2'b01: occ <= OCC_EMPTY;
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // Tail slides forward; no pop is possible while full.
                    if (out_fire) begin
                        head <= tail;
                        occ  <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (out_fire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_pop_skid.sv
// tb/tb_fifo_pop_skid.sv - queue-model bench for fifo_pop_skid
module tb_fifo_pop_skid;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_pop_skid_if #(.WIDTH(W)) bus ();
    fifo_pop_skid_if #(.WIDTH(W)) bus_w ();

    logic [1:0]  occ_main;
    logic [1:0]  occ_w;
    logic [15:0] cnt_main;
    logic [3:0]  cnt_w;

    fifo_pop_skid #(.WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .occupancy     (occ_main),
        .delivered_cnt (cnt_main)
    );

    // Narrow-counter copy sees identical inputs, so it tracks the same word stream.
    fifo_pop_skid #(.WIDTH(W), .CNT_WIDTH(4)) dut_w (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_w),
        .occupancy     (occ_w),
        .delivered_cnt (cnt_w)
    );

    assign bus_w.fifo_empty = bus.fifo_empty;
    assign bus_w.fifo_data  = bus.fifo_data;
    assign bus_w.m_ready    = bus.m_ready;

    int        n_cmp = 0;
    int        n_err = 0;
    int        exp_cnt = 0;
    int        pops_seen = 0;
    logic [7:0] src_q[$];
    logic [7:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input logic r, input logic rdy);
        logic pop_e;
        logic out_e;
        rst           = r;
        bus.m_ready   = rdy;
        bus.fifo_empty = (src_q.size() == 0);
        bus.fifo_data = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
        #3;
        pop_e = !r && (src_q.size() != 0) && (sb_q.size() < 2);
        chk("fifo_pop", {31'd0, bus.fifo_pop}, {31'd0, pop_e});
        if (!r) begin
            chk("m_valid", {31'd0, bus.m_valid}, {31'd0, sb_q.size() != 0});
            chk("occupancy", {30'd0, occ_main}, 32'(sb_q.size()));
            chk("delivered_cnt", {16'd0, cnt_main}, 32'(exp_cnt % 65536));
            chk("delivered_cnt_w4", {28'd0, cnt_w}, 32'(exp_cnt % 16));
            if (sb_q.size() != 0)
                chk("m_data", {24'd0, bus.m_data}, {24'd0, sb_q[0]});
        end
        if (bus.fifo_pop) pops_seen++;
        out_e = (sb_q.size() != 0) && rdy;
        @(posedge clk);
        if (r) begin
            sb_q.delete();
            src_q.delete();
            exp_cnt = 0;
        end else begin
            if (out_e) begin
                void'(sb_q.pop_front());
                exp_cnt++;
            end
            if (pop_e) sb_q.push_back(src_q.pop_front());
        end
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.m_ready    = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;

        // Reset then idle
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("rst_m_data", {24'd0, bus.m_data}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_main}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

        // Streaming 0x01..0x10 with ready held high
        for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
        pops_seen = 0;
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);
        chk("stream_pops", 32'(pops_seen), 32'd16);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1);
        chk("stream_cnt", {16'd0, cnt_main}, 32'd16);

        // Backpressure: only two pops while stalled
        src_q.push_back(8'hA1); src_q.push_back(8'hA2); src_q.push_back(8'hA3);
        pops_seen = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        chk("bp_pops", 32'(pops_seen), 32'd2);
        chk("bp_occ", {30'd0, occ_main}, 32'd2);
        chk("bp_head", {24'd0, bus.m_data}, 32'hA1);
        chk("bp_no_pop", {31'd0, bus.fifo_pop}, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        chk("bp_pops_total", 32'(pops_seen), 32'd3);
        chk("bp_cnt", {16'd0, cnt_main}, 32'd19);

        // Alternating ready with 8 queued words
        for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i % 2 == 0));
        chk("tog_occ", {30'd0, occ_main}, 32'd0);
        chk("tog_cnt", {16'd0, cnt_main}, 32'd27);

        // Reset with two words buffered
        src_q.push_back(8'h55); src_q.push_back(8'h66);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk("mid_occ_full", {30'd0, occ_main}, 32'd2);
        cycle(1'b1, 1'b0);
        chk("mid_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("mid_occ", {30'd0, occ_main}, 32'd0);
        chk("mid_m_data", {24'd0, bus.m_data}, 32'd0);
        chk("mid_cnt", {16'd0, cnt_main}, 32'd0);

        // 4-bit counter wrap over 17 words
        for (int i = 0; i < 17; i++) src_q.push_back(8'($urandom));
        for (int i = 0; i < 19; i++) cycle(1'b0, 1'b1);
        chk("wrap_cnt_w", {28'd0, cnt_w}, 32'd1);
        chk("wrap_cnt", {16'd0, cnt_main}, 32'd17);

        // Random traffic, random ready, occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && src_q.size() < 6)
                src_q.push_back(8'($urandom));
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);
        chk("drain_occ", {30'd0, occ_main}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
